// File: rtl/font_glyph_streamer_if.sv
// Request/pixel handshake bundle for font_glyph_streamer.
// Signal suffixes are named from the streamer's point of view.
interface font_glyph_streamer_if #(
    parameter int CHAR_BITS = 7,
    parameter int ROW_BITS  = 4
);
    logic                 req_valid_i;
    logic                 req_ready_o;
    logic [CHAR_BITS-1:0] req_char_i;
    logic [ROW_BITS-1:0]  req_row_i;
    logic                 req_inv_i;
    logic                 pix_valid_o;
    logic                 pix_ready_i;
    logic                 pix_o;
    logic                 pix_last_o;

    modport master (
        output req_valid_i, req_char_i, req_row_i, req_inv_i, pix_ready_i,
        input  req_ready_o, pix_valid_o, pix_o, pix_last_o
    );

    modport slave (
        input  req_valid_i, req_char_i, req_row_i, req_inv_i, pix_ready_i,
        output req_ready_o, pix_valid_o, pix_o, pix_last_o
    );
endinterface

// File: rtl/font_glyph_streamer.sv
// Font memory plus row serializer: fetch one {char,row} word, emit it MSB-first.
// Define FONT_WRITE_EN to add a read-first write port to the font memory.
module font_glyph_streamer #(
    parameter string FONT_FILE = "",
    parameter int    CHAR_BITS = 7,
    parameter int    GLYPH_W   = 8,
    parameter int    GLYPH_H   = 16,
    parameter int    ROW_BITS  = $clog2(GLYPH_H)
) (
    input  logic                          clk_i,
    input  logic                          rst_i,
`ifdef FONT_WRITE_EN
    input  logic                          wr_en_i,
    input  logic [CHAR_BITS+ROW_BITS-1:0] wr_addr_i,
    input  logic [GLYPH_W-1:0]            wr_data_i,
`endif
    font_glyph_streamer_if.slave          bus
);
    localparam int AW    = CHAR_BITS + ROW_BITS;
    localparam int DEPTH = 1 << AW;
    localparam int CW    = $clog2(GLYPH_W) + 1;

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_SHIFT} state_t;

    state_t             state_q, state_d;
    logic [GLYPH_W-1:0] mem [DEPTH];
    logic [GLYPH_W-1:0] rom_q;
    logic [GLYPH_W-1:0] shift_q;
    logic [CW-1:0]      cnt_q;
    logic               inv_q, oob_q;
    logic               accept, take;

    assign bus.req_ready_o = (state_q == S_IDLE) && !rst_i;
    assign accept          = bus.req_valid_i && bus.req_ready_o;
    assign bus.pix_valid_o = (state_q == S_SHIFT);
    assign take            = bus.pix_valid_o && bus.pix_ready_i;
    assign bus.pix_o       = shift_q[GLYPH_W-1];
    assign bus.pix_last_o  = bus.pix_valid_o && (cnt_q == '0);

    // Memory port has no reset; NBA ordering makes a same-edge read return old data.
    always_ff @(posedge clk_i) begin
`ifdef FONT_WRITE_EN
        if (wr_en_i) mem[wr_addr_i] <= wr_data_i;
`endif
        if (accept) rom_q <= mem[{bus.req_char_i, bus.req_row_i}];
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) state_q <= S_IDLE;
        else       state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            S_IDLE:  if (accept) state_d = S_LOAD;
            S_LOAD:  state_d = S_SHIFT;
            S_SHIFT: if (take && cnt_q == '0) state_d = S_IDLE;
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            shift_q <= '0;
            cnt_q   <= '0;
            inv_q   <= 1'b0;
            oob_q   <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: if (accept) begin
                    inv_q <= bus.req_inv_i;
                    oob_q <= (32'(bus.req_row_i) >= GLYPH_H);
                end
                // Rows past the glyph height read as blank, never as memory contents.
                S_LOAD: begin
                    shift_q <= (oob_q ? '0 : rom_q) ^ {GLYPH_W{inv_q}};
                    cnt_q   <= CW'(GLYPH_W - 1);
                end
                S_SHIFT: if (take) begin
                    shift_q <= shift_q << 1;
                    if (cnt_q != '0) cnt_q <= cnt_q - CW'(1);
                end
                default: ;
            endcase
        end
    end
endmodule
